// File: rtl/rs_issue_queue_pkg.sv
// Shared widths and ALU opcode encodings for the reservation-station slice.
package rs_issue_queue_pkg;

   localparam int ROB_WIDTH_BIT = 4;
   localparam int RS_TYPE_BIT   = 4;

   typedef enum logic [RS_TYPE_BIT-1:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9
   } alu_op_e;

endpackage

// File: rtl/rs_issue_queue_if.sv
// Dispatch, CDB broadcast and issue bundle between the pipeline and the reservation station.
interface rs_issue_queue_if
   import rs_issue_queue_pkg::*;
#(
   parameter int DEPTH_BIT  = 3,
   parameter int NUM_CDB    = 2,
   parameter int ROB_ID_BIT = ROB_WIDTH_BIT,
   parameter int OP_BIT     = RS_TYPE_BIT
) ();

   logic                           rdy_in;
   logic                           flush_in;
   logic                           inst_valid;
   logic [OP_BIT-1:0]              inst_op;
   logic [ROB_ID_BIT-1:0]          inst_rob_id;
   logic [31:0]                    inst_v1;
   logic [31:0]                    inst_v2;
   logic                           inst_has_dep1;
   logic                           inst_has_dep2;
   logic [ROB_ID_BIT-1:0]          inst_dep1;
   logic [ROB_ID_BIT-1:0]          inst_dep2;
   logic                           full;
   logic [DEPTH_BIT:0]             count;
   logic [NUM_CDB-1:0]             cdb_valid;
   logic [NUM_CDB*ROB_ID_BIT-1:0]  cdb_rob_id;
   logic [NUM_CDB*32-1:0]          cdb_value;
   logic                           issue_valid;
   logic                           issue_ready;
   logic [OP_BIT-1:0]              issue_op;
   logic [ROB_ID_BIT-1:0]          issue_rob_id;
   logic [31:0]                    issue_v1;
   logic [31:0]                    issue_v2;

   modport master (
      output rdy_in, flush_in, inst_valid, inst_op, inst_rob_id, inst_v1, inst_v2,
             inst_has_dep1, inst_has_dep2, inst_dep1, inst_dep2,
             cdb_valid, cdb_rob_id, cdb_value, issue_ready,
      input  full, count, issue_valid, issue_op, issue_rob_id, issue_v1, issue_v2
   );

   modport slave (
      input  rdy_in, flush_in, inst_valid, inst_op, inst_rob_id, inst_v1, inst_v2,
             inst_has_dep1, inst_has_dep2, inst_dep1, inst_dep2,
             cdb_valid, cdb_rob_id, cdb_value, issue_ready,
      output full, count, issue_valid, issue_op, issue_rob_id, issue_v1, issue_v2
   );

endinterface

// File: rtl/rs_issue_queue_chk.sv
// Simulation-only checks on dispatch protocol and occupancy bounds.
module rs_issue_queue_chk #(
   parameter int DEPTH_BIT = 3
) (
   input logic               clk_i,
   input logic               rst_ni,
   input logic               rdy_i,
   input logic               flush_i,
   input logic               inst_valid_i,
   input logic               full_i,
   input logic [DEPTH_BIT:0] count_i
);

   localparam logic [DEPTH_BIT:0] MAX_CNT = {1'b1, {DEPTH_BIT{1'b0}}};

   // Dispatch into a full station is a producer bug; the op is dropped, so only warn.
   always @(posedge clk_i) begin
      if (rst_ni && rdy_i) begin
         assert (!(inst_valid_i && full_i && !flush_i))
            else $warning("rs_issue_queue: dispatch while full was dropped");
         assert (count_i <= MAX_CNT)
            else $error("rs_issue_queue: occupancy above capacity");
      end
   end

endmodule

// File: rtl/rs_lowest_picker.sv
// Priority picker: reports whether any request bit is set and the index of the lowest one.
module rs_lowest_picker #(
   parameter int N     = 8,
   parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req_i,
   output logic             valid_o,
   output logic [IDX_W-1:0] idx_o
);

   // Scan from the top down so the lowest set bit is the last writer.
   always_comb begin
      valid_o = |req_i;
      idx_o   = {IDX_W{1'b0}};
      for (int i = N - 1; i >= 0; i--) begin
         idx_o = req_i[i] ? i[IDX_W-1:0] : idx_o;
      end
   end

endmodule

// File: rtl/rs_issue_queue.sv
// Reservation station for ALU ops: entries wait for both operands on the CDB ports,
// and the lowest-index ready entry moves into a registered valid/ready issue slot.
module rs_issue_queue
   import rs_issue_queue_pkg::*;
#(
   parameter int DEPTH_BIT  = 3,
   parameter int NUM_CDB    = 2,
   parameter int ROB_ID_BIT = ROB_WIDTH_BIT,
   parameter int OP_BIT     = RS_TYPE_BIT
) (
   input logic             clk_in,
   input logic             rst_in,
   rs_issue_queue_if.slave bus
);

   localparam int N = 1 << DEPTH_BIT;
   localparam logic [DEPTH_BIT:0] FULL_CNT = {1'b1, {DEPTH_BIT{1'b0}}};

   logic [N-1:0]           busy_q, pend1_q, pend2_q;
   logic [OP_BIT-1:0]      op_q   [N];
   logic [ROB_ID_BIT-1:0]  rob_q  [N];
   logic [31:0]            v1_q   [N];
   logic [31:0]            v2_q   [N];
   logic [ROB_ID_BIT-1:0]  tag1_q [N];
   logic [ROB_ID_BIT-1:0]  tag2_q [N];

   logic                   issue_valid_q, issue_valid_d;
   logic [OP_BIT-1:0]      issue_op_q, issue_op_d;
   logic [ROB_ID_BIT-1:0]  issue_rob_q, issue_rob_d;
   logic [31:0]            issue_v1_q, issue_v1_d;
   logic [31:0]            issue_v2_q, issue_v2_d;
   logic [DEPTH_BIT:0]     count_q, count_d;
   logic                   full_q, full_d;

   logic [ROB_ID_BIT-1:0]  cdb_tag_s [NUM_CDB];
   logic [31:0]            cdb_val_s [NUM_CDB];
   logic [NUM_CDB-1:0]     m1_s [N];
   logic [NUM_CDB-1:0]     m2_s [N];
   logic [NUM_CDB-1:0]     ins_m1_s, ins_m2_s;
   logic [N-1:0]           hit1_s, hit2_s, eligible_s;
   logic [31:0]            cv1_s  [N];
   logic [31:0]            cv2_s  [N];
   logic [31:0]            opv1_s [N];
   logic [31:0]            opv2_s [N];
   logic                   ins_hit1_s, ins_hit2_s;
   logic [31:0]            ins_cv1_s, ins_cv2_s;
   logic                   free_found_s, iss_found_s;
   logic [DEPTH_BIT-1:0]   free_idx_s, iss_idx_s;
   logic                   advance_s, load_s, ins_s;

   for (genvar p = 0; p < NUM_CDB; p++) begin : g_cdb
      assign cdb_tag_s[p] = bus.cdb_rob_id[p*ROB_ID_BIT +: ROB_ID_BIT];
      assign cdb_val_s[p] = bus.cdb_value[p*32 +: 32];
      assign ins_m1_s[p]  = bus.cdb_valid[p] && (bus.inst_dep1 == cdb_tag_s[p]);
      assign ins_m2_s[p]  = bus.cdb_valid[p] && (bus.inst_dep2 == cdb_tag_s[p]);
      for (genvar e = 0; e < N; e++) begin : g_ent
         assign m1_s[e][p] = bus.cdb_valid[p] && (tag1_q[e] == cdb_tag_s[p]);
         assign m2_s[e][p] = bus.cdb_valid[p] && (tag2_q[e] == cdb_tag_s[p]);
      end
   end

   // Lowest matching CDB port supplies the value: scan down so lower ports overwrite.
   always_comb begin
      ins_cv1_s = 32'd0;
      ins_cv2_s = 32'd0;
      for (int p = NUM_CDB - 1; p >= 0; p--) begin
         ins_cv1_s = ins_m1_s[p] ? cdb_val_s[p] : ins_cv1_s;
         ins_cv2_s = ins_m2_s[p] ? cdb_val_s[p] : ins_cv2_s;
      end
      ins_hit1_s = bus.inst_has_dep1 && (|ins_m1_s);
      ins_hit2_s = bus.inst_has_dep2 && (|ins_m2_s);
      for (int e = 0; e < N; e++) begin
         cv1_s[e] = 32'd0;
         cv2_s[e] = 32'd0;
         for (int p = NUM_CDB - 1; p >= 0; p--) begin
            cv1_s[e] = m1_s[e][p] ? cdb_val_s[p] : cv1_s[e];
            cv2_s[e] = m2_s[e][p] ? cdb_val_s[p] : cv2_s[e];
         end
         hit1_s[e]     = pend1_q[e] && (|m1_s[e]);
         hit2_s[e]     = pend2_q[e] && (|m2_s[e]);
         eligible_s[e] = busy_q[e] && (!pend1_q[e] || hit1_s[e]) && (!pend2_q[e] || hit2_s[e]);
         opv1_s[e]     = pend1_q[e] ? cv1_s[e] : v1_q[e];
         opv2_s[e]     = pend2_q[e] ? cv2_s[e] : v2_q[e];
      end
   end

   rs_lowest_picker #(.N(N), .IDX_W(DEPTH_BIT)) u_free_pick (
      .req_i   (~busy_q),
      .valid_o (free_found_s),
      .idx_o   (free_idx_s)
   );

   rs_lowest_picker #(.N(N), .IDX_W(DEPTH_BIT)) u_issue_pick (
      .req_i   (eligible_s),
      .valid_o (iss_found_s),
      .idx_o   (iss_idx_s)
   );

   // Issue slot advance, occupancy and full flag for the next cycle.
   always_comb begin
      advance_s = !issue_valid_q || bus.issue_ready;
      load_s    = advance_s && iss_found_s;
      ins_s     = bus.inst_valid && !full_q && free_found_s;
      count_d   = count_q + {{DEPTH_BIT{1'b0}}, ins_s} - {{DEPTH_BIT{1'b0}}, load_s};
      full_d    = (count_d == FULL_CNT);
      issue_valid_d = advance_s ? iss_found_s : issue_valid_q;
      if (load_s) begin
         issue_op_d  = op_q[iss_idx_s];
         issue_rob_d = rob_q[iss_idx_s];
         issue_v1_d  = opv1_s[iss_idx_s];
         issue_v2_d  = opv2_s[iss_idx_s];
      end else begin
         issue_op_d  = issue_op_q;
         issue_rob_d = issue_rob_q;
         issue_v1_d  = issue_v1_q;
         issue_v2_d  = issue_v2_q;
      end
   end

   // Entry array and issue slot; rdy_in low freezes everything, flush wins over all else.
   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         busy_q        <= {N{1'b0}};
         pend1_q       <= {N{1'b0}};
         pend2_q       <= {N{1'b0}};
         for (int e = 0; e < N; e++) begin
            op_q[e]   <= {OP_BIT{1'b0}};
            rob_q[e]  <= {ROB_ID_BIT{1'b0}};
            v1_q[e]   <= 32'd0;
            v2_q[e]   <= 32'd0;
            tag1_q[e] <= {ROB_ID_BIT{1'b0}};
            tag2_q[e] <= {ROB_ID_BIT{1'b0}};
         end
         issue_valid_q <= 1'b0;
         issue_op_q    <= {OP_BIT{1'b0}};
         issue_rob_q   <= {ROB_ID_BIT{1'b0}};
         issue_v1_q    <= 32'd0;
         issue_v2_q    <= 32'd0;
         count_q       <= {(DEPTH_BIT+1){1'b0}};
         full_q        <= 1'b0;
      end else if (bus.rdy_in) begin
         if (bus.flush_in) begin
            busy_q        <= {N{1'b0}};
            issue_valid_q <= 1'b0;
            count_q       <= {(DEPTH_BIT+1){1'b0}};
            full_q        <= 1'b0;
         end else begin
            for (int e = 0; e < N; e++) begin
               if (busy_q[e] && hit1_s[e]) begin
                  v1_q[e]    <= cv1_s[e];
                  pend1_q[e] <= 1'b0;
               end
               if (busy_q[e] && hit2_s[e]) begin
                  v2_q[e]    <= cv2_s[e];
                  pend2_q[e] <= 1'b0;
               end
            end
            if (load_s) begin
               busy_q[iss_idx_s] <= 1'b0;
            end
            // The free slot was idle at cycle start, so it never collides with wakeup or issue.
            if (ins_s) begin
               busy_q[free_idx_s]  <= 1'b1;
               op_q[free_idx_s]    <= bus.inst_op;
               rob_q[free_idx_s]   <= bus.inst_rob_id;
               v1_q[free_idx_s]    <= ins_hit1_s ? ins_cv1_s : bus.inst_v1;
               v2_q[free_idx_s]    <= ins_hit2_s ? ins_cv2_s : bus.inst_v2;
               pend1_q[free_idx_s] <= bus.inst_has_dep1 && !ins_hit1_s;
               pend2_q[free_idx_s] <= bus.inst_has_dep2 && !ins_hit2_s;
               tag1_q[free_idx_s]  <= bus.inst_dep1;
               tag2_q[free_idx_s]  <= bus.inst_dep2;
            end
            issue_valid_q <= issue_valid_d;
            issue_op_q    <= issue_op_d;
            issue_rob_q   <= issue_rob_d;
            issue_v1_q    <= issue_v1_d;
            issue_v2_q    <= issue_v2_d;
            count_q       <= count_d;
            full_q        <= full_d;
         end
      end
   end

   assign bus.issue_valid  = issue_valid_q;
   assign bus.issue_op     = issue_op_q;
   assign bus.issue_rob_id = issue_rob_q;
   assign bus.issue_v1     = issue_v1_q;
   assign bus.issue_v2     = issue_v2_q;
   assign bus.count        = count_q;
   assign bus.full         = full_q;

   rs_issue_queue_chk #(.DEPTH_BIT(DEPTH_BIT)) u_chk (
      .clk_i        (clk_in),
      .rst_ni       (rst_in),
      .rdy_i        (bus.rdy_in),
      .flush_i      (bus.flush_in),
      .inst_valid_i (bus.inst_valid),
      .full_i       (full_q),
      .count_i      (count_q)
   );

endmodule

// File: tb/tb_rs_issue_queue.sv
// Directed bench for rs_issue_queue: an entry-list model checked every cycle plus literal pins.
module tb_rs_issue_queue;
   import rs_issue_queue_pkg::*;

   localparam int DB = 3;
   localparam int NC = 2;
   localparam int RB = 4;
   localparam int OB = 4;
   localparam int N  = 1 << DB;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   bit   cmp_en = 1'b0;

   always #5 clk = ~clk;

   rs_issue_queue_if #(.DEPTH_BIT(DB), .NUM_CDB(NC), .ROB_ID_BIT(RB), .OP_BIT(OB)) bus ();

   rs_issue_queue #(.DEPTH_BIT(DB), .NUM_CDB(NC), .ROB_ID_BIT(RB), .OP_BIT(OB)) dut (
      .clk_in (clk),
      .rst_in (rst_n),
      .bus    (bus)
   );

   // Model: a list of waiting ops plus the op sitting in the issue slot.
   bit          m_busy [N];
   bit          m_p1   [N];
   bit          m_p2   [N];
   logic [3:0]  m_op   [N];
   logic [3:0]  m_rob  [N];
   logic [3:0]  m_t1   [N];
   logic [3:0]  m_t2   [N];
   logic [31:0] m_v1   [N];
   logic [31:0] m_v2   [N];
   bit          m_iv;
   logic [3:0]  m_iop, m_irob;
   logic [31:0] m_iv1, m_iv2;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int model_count();
      int c = 0;
      for (int e = 0; e < N; e++) c += int'(m_busy[e]);
      return c;
   endfunction

   function automatic bit cdb_match(input logic [3:0] tag);
      for (int p = 0; p < NC; p++)
         if (bus.cdb_valid[p] && bus.cdb_rob_id[p*RB +: RB] == tag) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] cdb_val(input logic [3:0] tag);
      for (int p = 0; p < NC; p++)
         if (bus.cdb_valid[p] && bus.cdb_rob_id[p*RB +: RB] == tag) return bus.cdb_value[p*32 +: 32];
      return 32'd0;
   endfunction

   task automatic model_reset();
      for (int e = 0; e < N; e++) begin
         m_busy[e] = 1'b0; m_p1[e] = 1'b0; m_p2[e] = 1'b0;
      end
      m_iv = 1'b0; m_iop = 4'd0; m_irob = 4'd0; m_iv1 = 32'd0; m_iv2 = 32'd0;
   endtask

   // Applies one clock edge of the station's rules to the model, from the inputs at that edge.
   task automatic model_step();
      int slot = -1;
      int pick = -1;
      if (!rst_n || !bus.rdy_in) return;
      if (bus.flush_in) begin
         for (int e = 0; e < N; e++) m_busy[e] = 1'b0;
         m_iv = 1'b0;
         return;
      end
      for (int e = N - 1; e >= 0; e--) if (!m_busy[e]) slot = e;
      for (int e = 0; e < N; e++) begin
         if (m_busy[e] && m_p1[e] && cdb_match(m_t1[e])) begin m_v1[e] = cdb_val(m_t1[e]); m_p1[e] = 1'b0; end
         if (m_busy[e] && m_p2[e] && cdb_match(m_t2[e])) begin m_v2[e] = cdb_val(m_t2[e]); m_p2[e] = 1'b0; end
      end
      if (!m_iv || bus.issue_ready) begin
         for (int e = N - 1; e >= 0; e--) if (m_busy[e] && !m_p1[e] && !m_p2[e]) pick = e;
         m_iv = (pick >= 0);
         if (pick >= 0) begin
            m_iop = m_op[pick]; m_irob = m_rob[pick]; m_iv1 = m_v1[pick]; m_iv2 = m_v2[pick];
            m_busy[pick] = 1'b0;
         end
      end
      if (bus.inst_valid && slot >= 0) begin
         m_busy[slot] = 1'b1;
         m_op[slot]  = bus.inst_op;
         m_rob[slot] = bus.inst_rob_id;
         m_t1[slot]  = bus.inst_dep1;
         m_t2[slot]  = bus.inst_dep2;
         m_p1[slot]  = bus.inst_has_dep1 && !cdb_match(bus.inst_dep1);
         m_p2[slot]  = bus.inst_has_dep2 && !cdb_match(bus.inst_dep2);
         m_v1[slot]  = (bus.inst_has_dep1 && !m_p1[slot]) ? cdb_val(bus.inst_dep1) : bus.inst_v1;
         m_v2[slot]  = (bus.inst_has_dep2 && !m_p2[slot]) ? cdb_val(bus.inst_dep2) : bus.inst_v2;
      end
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         check("m_issue_valid", 64'(bus.issue_valid), 64'(m_iv));
         check("m_count", 64'(bus.count), 64'(model_count()));
         check("m_full", 64'(bus.full), 64'(model_count() == N));
         if (m_iv) begin
            check("m_issue_op", 64'(bus.issue_op), 64'(m_iop));
            check("m_issue_rob", 64'(bus.issue_rob_id), 64'(m_irob));
            check("m_issue_v1", 64'(bus.issue_v1), 64'(m_iv1));
            check("m_issue_v2", 64'(bus.issue_v2), 64'(m_iv2));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic idle_inst();
      bus.inst_valid = 1'b0; bus.inst_has_dep1 = 1'b0; bus.inst_has_dep2 = 1'b0;
   endtask

   task automatic clear_cdb();
      bus.cdb_valid = 2'b00;
   endtask

   task automatic set_cdb(input int p, input logic [3:0] tag, input logic [31:0] val);
      bus.cdb_valid[p] = 1'b1;
      bus.cdb_rob_id[p*RB +: RB] = tag;
      bus.cdb_value[p*32 +: 32] = val;
   endtask

   task automatic set_inst(input logic [3:0] op, input logic [3:0] rob, input logic [31:0] v1,
                           input logic [31:0] v2, input logic hd1, input logic [3:0] d1,
                           input logic hd2, input logic [3:0] d2);
      bus.inst_valid = 1'b1; bus.inst_op = op; bus.inst_rob_id = rob;
      bus.inst_v1 = v1; bus.inst_v2 = v2;
      bus.inst_has_dep1 = hd1; bus.inst_dep1 = d1;
      bus.inst_has_dep2 = hd2; bus.inst_dep2 = d2;
   endtask

   initial begin
      rst_n = 1'b0;
      bus.rdy_in = 1'b1; bus.flush_in = 1'b0; bus.issue_ready = 1'b1;
      set_inst(4'd0, 4'd0, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0);
      idle_inst();
      bus.cdb_rob_id = 8'd0; bus.cdb_value = 64'd0; clear_cdb();
      model_reset();
      @(posedge clk); #1;
      cmp_en = 1'b1;
      check("rst_count", 64'(bus.count), 64'd0);
      check("rst_issue_valid", 64'(bus.issue_valid), 64'd0);
      check("rst_full", 64'(bus.full), 64'd0);
      check("rst_issue_v1", 64'(bus.issue_v1), 64'd0);
      rst_n = 1'b1;

      // Dep-free op: visible in the issue slot one edge after dispatch.
      set_inst(ALU_ADD, 4'd2, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0);
      tick(); idle_inst();
      check("lat_count1", 64'(bus.count), 64'd1);
      check("lat_iv0", 64'(bus.issue_valid), 64'd0);
      tick();
      check("lat_iv1", 64'(bus.issue_valid), 64'd1);
      check("lat_v1", 64'(bus.issue_v1), 64'd5);
      check("lat_v2", 64'(bus.issue_v2), 64'd7);
      check("lat_count0", 64'(bus.count), 64'd0);
      tick();

      // Insert-time bypass from port 1 while port 0 carries an unrelated tag.
      set_inst(ALU_SUB, 4'd4, 32'hdead, 32'd9, 1'b1, 4'd3, 1'b0, 4'd0);
      set_cdb(0, 4'd6, 32'h66); set_cdb(1, 4'd3, 32'h55);
      tick(); idle_inst(); clear_cdb();
      tick();
      check("byp_iv", 64'(bus.issue_valid), 64'd1);
      check("byp_v1", 64'(bus.issue_v1), 64'h55);
      check("byp_rob", 64'(bus.issue_rob_id), 64'd4);
      tick();

      // Wakeup with both ports matching: port 0 value must win.
      set_inst(ALU_AND, 4'd5, 32'd1, 32'hdead, 1'b0, 4'd0, 1'b1, 4'd5);
      tick(); idle_inst();
      tick();
      check("wake_wait", 64'(bus.issue_valid), 64'd0);
      set_cdb(0, 4'd5, 32'haa); set_cdb(1, 4'd5, 32'hbb);
      tick(); clear_cdb();
      check("wake_iv", 64'(bus.issue_valid), 64'd1);
      check("wake_v2", 64'(bus.issue_v2), 64'haa);
      tick();

      // Fill all entries, drop a ninth dispatch, then drain.
      for (int i = 0; i < N; i++) begin
         set_inst(ALU_OR, 4'(i), 32'(i), 32'(i), 1'b1, 4'd9, 1'b0, 4'd0);
         tick();
      end
      check("fill_count", 64'(bus.count), 64'd8);
      check("fill_full", 64'(bus.full), 64'd1);
      set_inst(ALU_OR, 4'd15, 32'd99, 32'd99, 1'b0, 4'd0, 1'b0, 4'd0);
      tick(); idle_inst();
      check("fill_drop", 64'(bus.count), 64'd8);
      set_cdb(0, 4'd9, 32'h99);
      tick(); clear_cdb();
      check("fill_unfull", 64'(bus.full), 64'd0);
      check("fill_count7", 64'(bus.count), 64'd7);
      check("fill_rob0", 64'(bus.issue_rob_id), 64'd0);
      for (int i = 0; i < N; i++) tick();
      check("drain_count", 64'(bus.count), 64'd0);
      check("drain_iv", 64'(bus.issue_valid), 64'd0);

      // Stall: slot holds op 10 while ops 12 (entry 0) and 11 (entry 1) wait.
      bus.issue_ready = 1'b0;
      set_inst(ALU_XOR, 4'd10, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0); tick();
      set_inst(ALU_XOR, 4'd11, 32'd2, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0); tick();
      set_inst(ALU_XOR, 4'd12, 32'd3, 32'd3, 1'b0, 4'd0, 1'b0, 4'd0); tick();
      idle_inst();
      for (int k = 0; k < 4; k++) begin
         check("stall_rob", 64'(bus.issue_rob_id), 64'd10);
         check("stall_count", 64'(bus.count), 64'd2);
         tick();
      end
      bus.issue_ready = 1'b1;
      tick();
      check("order_first", 64'(bus.issue_rob_id), 64'd12);
      tick();
      check("order_second", 64'(bus.issue_rob_id), 64'd11);
      tick();
      check("order_empty", 64'(bus.issue_valid), 64'd0);

      // Flush with five waiting entries and a same-cycle dispatch.
      for (int i = 0; i < 5; i++) begin
         set_inst(ALU_SLT, 4'(i), 32'd0, 32'd0, 1'b1, 4'd13, 1'b0, 4'd0);
         tick();
      end
      check("fl_count5", 64'(bus.count), 64'd5);
      set_inst(ALU_SLT, 4'd7, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0);
      bus.flush_in = 1'b1;
      tick(); bus.flush_in = 1'b0; idle_inst();
      check("fl_count0", 64'(bus.count), 64'd0);
      check("fl_iv", 64'(bus.issue_valid), 64'd0);
      set_cdb(0, 4'd13, 32'd1);
      tick(); clear_cdb();
      tick();
      check("fl_noins", 64'(bus.issue_valid), 64'd0);

      // Global stall ignores dispatch.
      bus.rdy_in = 1'b0;
      set_inst(ALU_ADD, 4'd3, 32'd4, 32'd4, 1'b0, 4'd0, 1'b0, 4'd0);
      tick(); tick(); idle_inst();
      check("rdy_count", 64'(bus.count), 64'd0);
      bus.rdy_in = 1'b1;
      tick();

      // Asynchronous reset mid-run with three entries busy and the slot occupied.
      bus.issue_ready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         set_inst(ALU_ADD, 4'(i), 32'(i), 32'(i), 1'b0, 4'd0, 1'b0, 4'd0);
         tick();
      end
      idle_inst();
      check("pre_rst_count", 64'(bus.count), 64'd3);
      check("pre_rst_iv", 64'(bus.issue_valid), 64'd1);
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      check("arst_count", 64'(bus.count), 64'd0);
      check("arst_iv", 64'(bus.issue_valid), 64'd0);
      check("arst_v1", 64'(bus.issue_v1), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      bus.issue_ready = 1'b1;
      tick(); tick();

      cmp_en = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
